rx_sample_packer: RTL and testbench
===================================

Name: rx_sample_packer

Overview:
Sits directly downstream of the RX decimation chain. Consumes the final I/Q pair qualified by hb_strobe, formats it into 16-bit bus words, and buffers them in an internal synchronous FIFO. The host-side read logic drains that FIFO. Provides a packet-ready indication and a sticky overrun flag. Single clock domain.

Parameters:
- DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 words of 16 bits (default 64).
- PKT_WORDS, 32, level at or above which pkt_ready asserts; must be less than or equal to 2**DEPTH_LOG2.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, accept new samples when high.
- eight_bit, input, 1, 1 = pack truncated 8-bit I/Q into one word; 0 = two 16-bit words.
- strobe_in, input, 1, sample-valid from the decimation chain (hb_strobe).
- i_in, input, 16, I sample, two's complement.
- q_in, input, 16, Q sample, two's complement.
- rd_req, input, 1, host read request, one word per cycle.
- rd_data, output, 16, read word, registered.
- rd_valid, output, 1, rd_data holds a popped word this cycle.
- level, output, DEPTH_LOG2+1, current FIFO occupancy in words.
- pkt_ready, output, 1, level >= PKT_WORDS.
- overrun, output, 1, sticky: a sample was dropped.
- clear_status, input, 1, clears overrun.

Behaviour:
- Reset: FIFO empty, level=0, rd_data=0, rd_valid=0, pkt_ready=0, overrun=0, FSM=IDLE. Reset mid-operation discards any half-written I/Q pair.
- FSM states are IDLE and WR_Q.
- IDLE, strobe_in & enable & eight_bit:
  - If free >= 1, write {i_in[15:8], q_in[15:8]}; stay IDLE.
  - Else drop the sample and set overrun.
- IDLE, strobe_in & enable & !eight_bit:
  - If free >= 2, write i_in this cycle, latch q_in, go to WR_Q.
  - Else drop the whole sample (no lone I word) and set overrun.
- WR_Q: write the latched Q, return to IDLE. This completes even if enable drops.
- A strobe arriving while in WR_Q is dropped and sets overrun.
- strobe_in with enable=0 is ignored; no overrun is set.
- Read path:
  - rd_req & !empty pops the FIFO; rd_data and rd_valid are updated on the next clock edge (1-cycle latency).
  - rd_req when empty: no pop, rd_valid=0 next cycle, rd_data holds its value.
- A push and a pop in the same cycle are both performed; level is unchanged.
- level and pkt_ready are registered and reflect the post-edge occupancy.
- Free space is 2**DEPTH_LOG2 - level. Full is level == 2**DEPTH_LOG2.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth; level is a separate counter.
- Overrun:
  - Set on any drop.
  - clear_status clears it the next cycle.
  - If a drop and clear_status occur in the same cycle, set wins.
- The eight_bit input is sampled only in IDLE. A change while in WR_Q takes effect on the next sample.

Decomposition:
- Shared package rx_pkt_pkg holds:
  - FSM state encoding (ST_IDLE, ST_WR_Q).
  - Mode constants MODE_16, MODE_8.
  - A function packing the 8-bit word.
- One sub-module: rx_sync_fifo, a parameterised single-clock FIFO with push, pop, level, full and empty. It is reusable for the TX side.

Test Plan:
- 16-bit mode: strobe with I=0x1234, Q=0xABCD, then 4 rd_req cycles -> rd_valid pulses twice with rd_data=0x1234 then 0xABCD; level goes 0,1,2 on write then back to 0; overrun stays 0.
- 8-bit mode: I=0x7F80, Q=0x8001 -> single word 0x7F80; level=1.
- Fill to 63 of 64 words in 16-bit mode, then strobe -> sample dropped, level stays 63, overrun=1. Assert clear_status -> overrun=0 the next cycle.
- Strobes on consecutive cycles in 16-bit mode -> second is dropped, overrun=1, FIFO holds exactly I,Q of the first sample.
- Continuous strobe every 4 cycles with rd_req held high -> level never exceeds 2, no overrun, output order is I0,Q0,I1,Q1...
- Reset asserted in WR_Q -> next cycle level=0, rd_valid=0, FSM=IDLE; the next strobe writes a fresh I first. Also check pkt_ready asserts exactly when level reaches 32.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the RX sample packer: FSM encoding, pack-mode
// constants and the 8-bit I/Q word formatter.
package rx_pkt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR_Q = 1'b1
  } pk_state_e;

  localparam logic MODE_16 = 1'b0;
  localparam logic MODE_8  = 1'b1;

  // Keep only the top byte of each component; I lands in the high byte.
  function automatic logic [15:0] pack8(input logic [15:0] i_s, input logic [15:0] q_s);
    return {i_s[15:8], q_s[15:8]};
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered read data and an explicit occupancy
// counter; shared by the RX and TX paths.
module rx_sync_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  pop_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_MAX = DEPTH;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [WIDTH-1:0]      pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  push_ok, pop_ok;

  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);

  always_comb begin
    push_ok     = push & ~full;
    pop_ok      = pop & ~empty;
    wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d     = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
    else if (!push_ok && pop_ok) level_d = level_q - LVL_ONE;
    // An empty read leaves the last word in place.
    pop_data_d  = pop_ok ? mem_q[rd_ptr_q] : pop_data_q;
    pop_valid_d = pop_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign level     = level_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;

endmodule

// File: rtl/rx_sample_packer.sv
// Formats decimated I/Q samples into 16-bit words and buffers them for the
// host; flags packet-ready and sticky overrun on dropped samples.
module rx_sample_packer
  import rx_pkt_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int PKT_WORDS  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  eight_bit,
  input  logic                  strobe_in,
  input  logic [15:0]           i_in,
  input  logic [15:0]           q_in,
  input  logic                  rd_req,
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  pkt_ready,
  output logic                  overrun,
  input  logic                  clear_status
);

  localparam logic [DEPTH_LOG2:0] LVL_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_PKT   = PKT_WORDS;
  localparam logic [DEPTH_LOG2:0] FREE_TWO  = 2;

  pk_state_e           state_q, state_d;
  logic [15:0]         q_lat_q, q_lat_d;
  logic                overrun_q, overrun_d;
  logic                push, drop, fifo_full, fifo_empty;
  logic [15:0]         push_data;
  logic [DEPTH_LOG2:0] free;

  assign free = LVL_DEPTH - level;

  always_comb begin
    state_d   = state_q;
    q_lat_d   = q_lat_q;
    push      = 1'b0;
    push_data = '0;
    drop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_in && enable) begin
          if (eight_bit == MODE_8) begin
            if (!fifo_full) begin
              push      = 1'b1;
              push_data = pack8(i_in, q_in);
            end else begin
              drop = 1'b1;
            end
          end else if (free >= FREE_TWO) begin
            // Room for both words is reserved up front so I never lands alone.
            push      = 1'b1;
            push_data = i_in;
            q_lat_d   = q_in;
            state_d   = ST_WR_Q;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_WR_Q: begin
        push      = 1'b1;
        push_data = q_lat_q;
        state_d   = ST_IDLE;
        drop      = strobe_in & enable;
      end
      default: state_d = ST_IDLE;
    endcase
    overrun_d = drop ? 1'b1 : (clear_status ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      q_lat_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_lat_q   <= q_lat_d;
      overrun_q <= overrun_d;
    end
  end

  rx_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(16)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_req & ~fifo_empty),
    .pop_data  (rd_data),
    .pop_valid (rd_valid),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pkt_ready = (level >= LVL_PKT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed bench for rx_sample_packer: table of single-sample vectors plus
// hand sequences for fill/overrun, back-to-back strobes, streaming and reset.
module tb_rx_sample_packer;

  logic        clock = 1'b0;
  logic        reset, enable, eight_bit, strobe_in, rd_req, clear_status;
  logic [15:0] i_in, q_in, rd_data;
  logic        rd_valid, pkt_ready, overrun;
  logic [6:0]  level;

  int n_pass = 0;
  int n_tot  = 0;

  rx_sample_packer #(.DEPTH_LOG2(6), .PKT_WORDS(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .eight_bit(eight_bit),
    .strobe_in(strobe_in), .i_in(i_in), .q_in(q_in), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .pkt_ready(pkt_ready), .overrun(overrun), .clear_status(clear_status)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        eb;
    logic [15:0] i;
    logic [15:0] q;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pop_word(input string name, input logic [15:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({name, "_valid"}, rd_valid, 1);
    chk({name, "_data"}, rd_data, exp);
  endtask

  task automatic strobe(input logic eb, input logic [15:0] i, input logic [15:0] q);
    eight_bit = eb; i_in = i; q_in = q; strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int          max_lvl, n_out;
    int          exp_lvl;

    vecs[0] = '{1'b0, 16'h1234, 16'hABCD, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{1'b1, 16'h7F80, 16'h8001, 1, 16'h7F80, 16'h0000};
    vecs[2] = '{1'b1, 16'h8000, 16'h7FFF, 1, 16'h807F, 16'h0000};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 2, 16'hFFFF, 16'h0000};

    reset = 1'b1; enable = 1'b1; eight_bit = 1'b0; strobe_in = 1'b0;
    rd_req = 1'b0; clear_status = 1'b0; i_in = '0; q_in = '0;
    tick(); tick();
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // Single-sample table
    for (int v = 0; v < 4; v++) begin
      strobe(vecs[v].eb, vecs[v].i, vecs[v].q);
      chk($sformatf("v%0d_lvl_a", v), level, 1);
      tick();
      chk($sformatf("v%0d_lvl_b", v), level, vecs[v].nw);
      pop_word($sformatf("v%0d_w0", v), vecs[v].w0);
      if (vecs[v].nw == 2) pop_word($sformatf("v%0d_w1", v), vecs[v].w1);
      rd_req = 1'b1; tick(); tick(); rd_req = 1'b0;
      chk($sformatf("v%0d_empty_valid", v), rd_valid, 0);
      chk($sformatf("v%0d_lvl_end", v), level, 0);
      chk($sformatf("v%0d_ovr", v), overrun, 0);
    end

    // enable low: strobe ignored, no overrun
    enable = 1'b0;
    strobe(1'b0, 16'h4444, 16'h5555);
    tick();
    chk("dis_level", level, 0);
    chk("dis_ovr", overrun, 0);
    enable = 1'b1;

    // Fill to 62 in 16-bit mode, checking pkt_ready threshold
    for (int k = 0; k < 31; k++) begin
      strobe(1'b0, 16'(k), 16'(~k));
      exp_lvl = 2 * k + 1;
      chk($sformatf("fill%0d_lvl_i", k), level, exp_lvl);
      chk($sformatf("fill%0d_pkt_i", k), pkt_ready, (exp_lvl >= 32) ? 1 : 0);
      tick();
      exp_lvl = 2 * k + 2;
      chk($sformatf("fill%0d_lvl_q", k), level, exp_lvl);
      chk($sformatf("fill%0d_pkt_q", k), pkt_ready, (exp_lvl >= 32) ? 1 : 0);
    end
    strobe(1'b1, 16'hAA00, 16'hBB00);
    chk("fill63_lvl", level, 63);
    strobe(1'b0, 16'h1111, 16'h2222);
    chk("drop16_lvl", level, 63);
    chk("drop16_ovr", overrun, 1);
    tick();
    chk("drop16_noq", level, 63);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    chk("clr_ovr", overrun, 0);
    strobe(1'b1, 16'hCC00, 16'hDD00);
    chk("full_lvl", level, 64);
    chk("full_ovr", overrun, 0);
    clear_status = 1'b1;
    strobe(1'b1, 16'hEE00, 16'hFF00);
    clear_status = 1'b0;
    chk("setwins_ovr", overrun, 1);
    chk("setwins_lvl", level, 64);
    pop_word("fifo_head", 16'h0000);
    chk("pop_full_lvl", level, 63);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_level", level, 0);
    chk("rst2_ovr", overrun, 0);
    chk("rst2_pkt", pkt_ready, 0);

    // Back-to-back strobes: second lands in WR_Q and is dropped
    eight_bit = 1'b0; i_in = 16'h1111; q_in = 16'h2222; strobe_in = 1'b1;
    tick();
    i_in = 16'h3333; q_in = 16'h4444;
    tick();
    strobe_in = 1'b0;
    tick();
    chk("b2b_lvl", level, 2);
    chk("b2b_ovr", overrun, 1);
    pop_word("b2b_i", 16'h1111);
    pop_word("b2b_q", 16'h2222);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("b2b_empty_valid", rd_valid, 0);
    chk("b2b_hold_data", rd_data, 16'h2222);
    clear_status = 1'b1; tick(); clear_status = 1'b0;

    // Streaming: strobe every 4 cycles with rd_req held
    max_lvl = 0; n_out = 0;
    rd_req = 1'b1; eight_bit = 1'b0;
    for (int c = 0; c < 28; c++) begin
      if (c % 4 == 0 && c < 24) begin
        i_in = 16'h1000 + 16'(c / 4); q_in = 16'h2000 + 16'(c / 4); strobe_in = 1'b1;
        exp_q.push_back(i_in); exp_q.push_back(q_in);
      end else strobe_in = 1'b0;
      tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (rd_valid) begin
        n_out++;
        if (exp_q.size() > 0) chk("stream_data", rd_data, exp_q.pop_front());
        else chk("stream_extra", 1, 0);
      end
    end
    strobe_in = 1'b0; rd_req = 1'b0;
    chk("stream_count", n_out, 12);
    chk("stream_maxlvl_le2", (max_lvl <= 2) ? 1 : 0, 1);
    chk("stream_ovr", overrun, 0);

    // Reset while in WR_Q discards the pending Q
    strobe(1'b0, 16'h7777, 16'h8888);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstwq_lvl", level, 0);
    chk("rstwq_valid", rd_valid, 0);
    tick();
    chk("rstwq_idle_lvl", level, 0);
    strobe(1'b0, 16'h5555, 16'h6666);
    tick();
    chk("rstwq_new_lvl", level, 2);
    pop_word("rstwq_i", 16'h5555);
    pop_word("rstwq_q", 16'h6666);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
